// File: rtl/ins_encode_queue.sv
// Packs field-level commands into 32-bit instruction words and queues them for fetch injection.
// Latency: 1 cycle, accept to ins_valid. Backpressure: cmd_ready drops only when the FIFO is full, with no bypass.
module ins_encode_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [2:0]       cmd_funct,
  input  logic [4:0]       cmd_rd,
  input  logic [4:0]       cmd_ra,
  input  logic [4:0]       cmd_rb,
  input  logic [15:0]      cmd_imm,
  input  logic             cmd_mem_rd,
  output logic             ins_valid,
  input  logic             ins_ready,
  output logic [31:0]      ins,
  output logic [CNT_W-1:0] count,
  output logic             enc_err,
  output logic [7:0]       err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [3:0] OP_CALI   = 4'h1;
  localparam logic [3:0] OP_SHIFT  = 4'h2;
  localparam logic [3:0] OP_LOADI  = 4'h3;
  localparam logic [3:0] OP_MEMOP  = 4'h4;
  localparam logic [3:0] OP_BRANCH = 4'h5;
  localparam logic [3:0] OP_EXC    = 4'h6;
  localparam logic [3:0] OP_MULTI  = 4'h7;
  localparam logic [3:0] OP_CAL    = 4'hB;

  logic [31:0]      enc_word;
  logic             enc_legal;
  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             accept;
  logic             push;
  logic             pop;
  logic [4:0]       ra_imm_mix;

  // imm[15:12] shares bits [25:22] with ra; the two are ORed together.
  assign ra_imm_mix = {1'b0, cmd_imm[15:12]} | cmd_ra;

  always_comb begin
    enc_word      = '0;
    enc_legal     = 1'b1;
    enc_word[4:1] = cmd_op;
    enc_word[7:5] = cmd_funct;
    case (cmd_op)
      OP_CAL, OP_SHIFT: begin
        enc_word[31:27] = cmd_rd;
        enc_word[26:22] = cmd_ra;
        enc_word[21:17] = cmd_rb;
      end
      OP_CALI, OP_LOADI: begin
        enc_word[25:10] = cmd_imm;
        enc_word[26:22] = ra_imm_mix;
        enc_word[31:27] = cmd_rd;
      end
      OP_MEMOP: begin
        enc_word[25:10] = cmd_imm;
        enc_word[26:22] = ra_imm_mix;
        enc_word[31:27] = cmd_mem_rd ? cmd_rd : cmd_rb;
        enc_word[8]     = cmd_mem_rd;
      end
      OP_BRANCH: begin
        enc_word[25:10] = cmd_imm;
        enc_word[26:22] = ra_imm_mix;
        case (cmd_funct)
          3'b000, 3'b010:         enc_word[31:27] = cmd_rd;
          3'b001, 3'b011, 3'b111: enc_word[31:27] = cmd_rb;
          default:                enc_legal = 1'b0;
        endcase
      end
      OP_EXC: begin
        enc_legal = (cmd_funct == 3'b001) || (cmd_funct == 3'b010);
      end
      OP_MULTI: begin
        enc_word[26:22] = cmd_ra;
        case (cmd_funct)
          3'b111:                 enc_word[31:27] = cmd_rd;
          3'b101, 3'b010, 3'b000: ;
          default:                enc_legal = 1'b0;
        endcase
      end
      default: enc_legal = 1'b0;
    endcase
  end

  assign cmd_ready = (count != CNT_W'(DEPTH));
  assign ins_valid = (count != '0);
  assign accept    = cmd_valid && cmd_ready;
  // flush wins over both push and pop in the same cycle.
  assign push      = accept && enc_legal && !flush;
  assign pop       = ins_valid && ins_ready && !flush;
  assign ins       = ins_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      enc_err <= accept && !enc_legal;
      if (accept && !enc_legal && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ins_encode_queue.sv
// Randomized scoreboard bench for ins_encode_queue against a field-level reference model.
module tb_ins_encode_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  localparam logic [3:0] CALI = 4'h1, SHIFT = 4'h2, LOADI = 4'h3, MEMOP = 4'h4;
  localparam logic [3:0] BRANCH = 4'h5, EXC = 4'h6, MULTI = 4'h7, CAL = 4'hB;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_op = '0;
  logic [2:0]       cmd_funct = '0;
  logic [4:0]       cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
  logic [15:0]      cmd_imm = '0;
  logic             cmd_mem_rd = 1'b0;
  logic             ins_valid;
  logic             ins_ready = 1'b0;
  logic [31:0]      ins;
  logic [CNT_W-1:0] count;
  logic             enc_err;
  logic [7:0]       err_cnt;

  ins_encode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_funct(cmd_funct), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra),
    .cmd_rb(cmd_rb), .cmd_imm(cmd_imm), .cmd_mem_rd(cmd_mem_rd),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
    .count(count), .enc_err(enc_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  int          exp_err_cnt = 0;
  logic        exp_enc_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] op, input logic [2:0] f);
    case (op)
      CAL, CALI, SHIFT, LOADI, MEMOP: return 1'b1;
      BRANCH: return (f == 0) || (f == 1) || (f == 2) || (f == 3) || (f == 7);
      EXC:    return (f == 1) || (f == 2);
      MULTI:  return (f == 7) || (f == 5) || (f == 2) || (f == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_word(input logic [3:0] op, input logic [2:0] f,
      input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
      input logic [15:0] imm, input logic mrd);
    int unsigned w;
    int unsigned top;
    w = (int'(op) * 2) + (int'(f) * 32);
    top = 0;
    case (op)
      CAL, SHIFT: begin
        top = rd;
        w = w | (int'(ra) << 22) | (int'(rb) << 17);
      end
      CALI, LOADI: begin
        top = rd;
        w = w | (int'(imm) << 10) | (int'(ra) << 22);
      end
      MEMOP: begin
        top = mrd ? rd : rb;
        w = w | (int'(imm) << 10) | (int'(ra) << 22) | (int'(mrd) << 8);
      end
      BRANCH: begin
        top = (f == 0 || f == 2) ? rd : rb;
        w = w | (int'(imm) << 10) | (int'(ra) << 22);
      end
      MULTI: begin
        top = (f == 7) ? rd : 0;
        w = w | (int'(ra) << 22);
      end
      default: ;
    endcase
    return 32'(w | (top << 27));
  endfunction

  // Reference model: evaluates the handshake late in each cycle, just before the edge.
  always begin
    @(negedge clk);
    #4;
    if (rst_n) begin
      exp_enc_err = 1'b0;
      if (flush) exp_q.delete();
      if (cmd_valid && cmd_ready) begin
        if (!is_legal(cmd_op, cmd_funct)) begin
          exp_enc_err = 1'b1;
          if (exp_err_cnt < 255) exp_err_cnt++;
        end else if (!flush) begin
          exp_q.push_back(model_word(cmd_op, cmd_funct, cmd_rd, cmd_ra, cmd_rb, cmd_imm, cmd_mem_rd));
        end
      end
    end
  end

  // Monitor: compares presented outputs against the scoreboard each cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("count", 32'(count), 32'(exp_q.size()));
      check("ins_valid", 32'(ins_valid), 32'(exp_q.size() != 0));
      check("enc_err", 32'(enc_err), 32'(exp_enc_err));
      check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
      if (exp_q.size() != 0) begin
        check("ins_word", ins, exp_q[0]);
        if (ins_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] op, input logic [2:0] f, input logic [4:0] rd,
      input logic [4:0] ra, input logic [4:0] rb, input logic [15:0] imm, input logic mrd);
    cmd_op = op; cmd_funct = f; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    cmd_imm = imm; cmd_mem_rd = mrd;
  endtask

  task automatic rand_fields(input bit legal);
    logic [3:0] op;
    logic [2:0] f;
    logic [3:0] ops [8] = '{CAL, CALI, SHIFT, LOADI, MEMOP, BRANCH, EXC, MULTI};
    if (legal) begin
      op = ops[$urandom_range(0, 7)];
      do f = 3'($urandom_range(0, 7)); while (!is_legal(op, f));
    end else begin
      op = 4'($urandom_range(0, 15));
      f  = 3'($urandom_range(0, 7));
    end
    set_cmd(op, f, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'($urandom));
  endtask

  // Holds the current command until accepted; called and returns at posedge+1.
  task automatic send();
    bit done = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = cmd_ready;
      align();
    end
    cmd_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: cmd_ready stayed 0, expected 1 within 100 cycles");
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    ins_ready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = (count == 0);
      align();
    end
    ins_ready = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: count %0d, expected 0 within 50 cycles", count);
    end
  endtask

  initial begin
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_ins_valid", 32'(ins_valid), 32'd0);
    check("rst_ins", ins, 32'd0);
    check("rst_enc_err", 32'(enc_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    align();
    rst_n = 1'b1;
    align();

    // CAL directed word
    set_cmd(CAL, 3'b011, 5'd5, 5'd3, 5'd7, 16'h0, 1'b0);
    send();
    @(negedge clk);
    check("cal_word", ins, 32'h28CE0076);
    check("cal_count", 32'(count), 32'd1);
    align();
    drain();

    // MEMOP store then load
    set_cmd(MEMOP, 3'b000, 5'd0, 5'd2, 5'd9, 16'h0010, 1'b0);
    send();
    @(negedge clk);
    check("memop_store", ins, 32'h48804008);
    align();
    set_cmd(MEMOP, 3'b000, 5'd4, 5'd2, 5'd9, 16'h0010, 1'b1);
    send();
    ins_ready = 1'b1;
    align();
    ins_ready = 1'b0;
    @(negedge clk);
    check("memop_load", ins, 32'h20804108);
    align();
    drain();

    // Illegal commands and saturation
    set_cmd(BRANCH, 3'b100, 5'd1, 5'd1, 5'd1, 16'h1, 1'b0);
    send();
    set_cmd(EXC, 3'b000, 5'd1, 5'd1, 5'd1, 16'h1, 1'b0);
    send();
    @(negedge clk);
    check("err_cnt_two", 32'(err_cnt), 32'd2);
    align();
    set_cmd(4'h0, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
    cmd_valid = 1'b1;
    repeat (300) align();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("err_cnt_sat", 32'(err_cnt), 32'hFF);
    align();

    // Fill to DEPTH with the consumer stalled
    for (int i = 0; i < 4; i++) begin
      rand_fields(1'b1);
      send();
    end
    rand_fields(1'b1);
    cmd_valid = 1'b1;
    @(negedge clk);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_count", 32'(count), 32'd4);
    align();
    ins_ready = 1'b1;
    send();
    drain();

    // Steady push+pop at count 2
    for (int i = 0; i < 2; i++) begin
      rand_fields(1'b1);
      send();
    end
    ins_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_fields(1'b1);
      cmd_valid = 1'b1;
      @(negedge clk);
      check("pushpop_count", 32'(count), 32'd2);
      align();
    end
    cmd_valid = 1'b0;
    drain();

    // Asynchronous reset mid-stream at count 3
    for (int i = 0; i < 3; i++) begin
      rand_fields(1'b1);
      send();
    end
    #1 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_ins_valid", 32'(ins_valid), 32'd0);
    check("arst_err_cnt", 32'(err_cnt), 32'd0);
    exp_q.delete();
    exp_err_cnt = 0;
    exp_enc_err = 1'b0;
    #1 rst_n = 1'b1;
    align();

    // Flush with a legal command, then with an illegal one
    for (int i = 0; i < 2; i++) begin
      rand_fields(1'b1);
      send();
    end
    rand_fields(1'b1);
    cmd_valid = 1'b1;
    flush = 1'b1;
    align();
    flush = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("flush_count", 32'(count), 32'd0);
    check("flush_ins_valid", 32'(ins_valid), 32'd0);
    align();
    set_cmd(EXC, 3'b111, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
    cmd_valid = 1'b1;
    flush = 1'b1;
    align();
    flush = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("flush_enc_err", 32'(enc_err), 32'd1);
    align();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rand_fields($urandom_range(0, 9) < 7);
      cmd_valid = 1'($urandom);
      ins_ready = 1'($urandom);
      flush     = ($urandom_range(0, 39) == 0);
      align();
    end
    cmd_valid = 1'b0;
    flush = 1'b0;
    drain();
    align();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
